// File: rtl/minesweeper_pkg.sv
// Shared action codes, button indices and centre-FSM state type for the
// minesweeper input path.
package minesweeper_pkg;

  localparam logic [2:0] ACT_NONE = 3'b000;
  localparam logic [2:0] ACT_C1   = 3'b001;
  localparam logic [2:0] ACT_C2   = 3'b010;
  localparam logic [2:0] ACT_U    = 3'b100;
  localparam logic [2:0] ACT_R    = 3'b101;
  localparam logic [2:0] ACT_D    = 3'b110;
  localparam logic [2:0] ACT_L    = 3'b111;

  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_U   = 1;
  localparam int unsigned BTN_R   = 2;
  localparam int unsigned BTN_D   = 3;
  localparam int unsigned BTN_L   = 4;
  localparam int unsigned NUM_BTN = 5;

  typedef enum logic {
    StIdle,
    StWait
  } c_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/click_action_queue.sv
// Debounced button front end with single/double centre-click detection and a
// small action FIFO read by the game controller over valid/ack.
module click_action_queue
  import minesweeper_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned DBL_WINDOW = 20,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         clear_n,
  input  logic [4:0]                   btn_raw,
  input  logic                         dbl_en,
  input  logic                         ack,
  output logic [2:0]                   action,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int unsigned WinW = $clog2(DBL_WINDOW + 1);
  localparam logic [WinW-1:0] WinLast = WinW'(DBL_WINDOW);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [NUM_BTN-1:0] press;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk_i  (clk),
      .rst_ni (clear_n),
      .btn_i  (btn_raw[b]),
      .press_o(press[b])
    );
  end

  // Centre click FSM
  c_state_e        c_state_q, c_state_d;
  logic [WinW-1:0] win_q, win_d;
  logic            c_evt;
  logic [2:0]      c_code;

  always_comb begin
    c_state_d = c_state_q;
    win_d     = win_q;
    c_evt     = 1'b0;
    c_code    = ACT_NONE;
    case (c_state_q)
      StIdle: begin
        if (press[BTN_C]) begin
          if (dbl_en) begin
            c_state_d = StWait;
            win_d     = WinW'(1);
          end else begin
            c_evt  = 1'b1;
            c_code = ACT_C1;
          end
        end
      end
      StWait: begin
        // A second press wins even on the final window cycle.
        if (press[BTN_C]) begin
          c_evt     = 1'b1;
          c_code    = ACT_C2;
          c_state_d = StIdle;
          win_d     = '0;
        end else if (win_q == WinLast) begin
          c_evt     = 1'b1;
          c_code    = ACT_C1;
          c_state_d = StIdle;
          win_d     = '0;
        end else begin
          win_d = win_q + WinW'(1);
        end
      end
      default: begin
        c_state_d = StIdle;
        win_d     = '0;
      end
    endcase
  end

  // Fixed-priority arbiter: centre > U > R > D > L
  logic [4:0] evs;
  logic       multi;
  logic       push;
  logic [2:0] push_code;

  always_comb begin
    evs       = {c_evt, press[BTN_U], press[BTN_R], press[BTN_D], press[BTN_L]};
    multi     = |(evs & (evs - 5'd1));
    push      = |evs;
    push_code = ACT_NONE;
    if (c_evt)             push_code = c_code;
    else if (press[BTN_U]) push_code = ACT_U;
    else if (press[BTN_R]) push_code = ACT_R;
    else if (press[BTN_D]) push_code = ACT_D;
    else if (press[BTN_L]) push_code = ACT_L;
  end

  // FIFO
  logic [2:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            drop_q, drop_d;
  logic            full, pop, do_push;

  always_comb begin
    full    = (count_q == CntFull);
    pop     = ack && (count_q != '0);
    do_push = push && (!full || pop);
    drop_d  = multi || (push && full && !pop);
    count_d = count_q;
    if (do_push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      c_state_q <= StIdle;
      win_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ACT_NONE;
    end else begin
      c_state_q <= c_state_d;
      win_q     <= win_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign valid  = (count_q != '0);
  assign action = valid ? mem_q[rd_ptr_q] : ACT_NONE;
  assign count  = count_q;
  assign drop   = drop_q;

endmodule
